// File: rtl/shift_deserializer_if.sv
// Bundle between the serial receive front end and its consumer.
// The consumer side (master) drives bit strobes and ready; the receiver (slave) drives words.
interface shift_deserializer_if #(
    parameter int SHIFT_WIDTH = 8
);
    localparam int CW = $clog2(SHIFT_WIDTH);

    logic                   sclr;
    logic                   enable;
    logic                   shiftin;
    logic                   data_ready;
    logic [SHIFT_WIDTH-1:0] q;
    logic [CW-1:0]          bit_count;
    logic [SHIFT_WIDTH-1:0] data_out;
    logic                   data_valid;
    logic                   overrun;

    modport master (
        output sclr, enable, shiftin, data_ready,
        input  q, bit_count, data_out, data_valid, overrun
    );

    modport slave (
        input  sclr, enable, shiftin, data_ready,
        output q, bit_count, data_out, data_valid, overrun
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles SHIFT_WIDTH-bit words from enabled bits and
// offers each finished word in a one-entry holding register with a sticky overrun flag.
module shift_deserializer #(
    parameter int    SHIFT_WIDTH     = 8,
    parameter string SHIFT_DIRECTION = "LEFT"
) (
    input  logic                clock,
    input  logic                aclr_n,
    shift_deserializer_if.slave bus
);
    localparam int            W         = SHIFT_WIDTH;
    localparam int            CW        = $clog2(SHIFT_WIDTH);
    localparam bit            DIR_RIGHT = (SHIFT_DIRECTION == "RIGHT");
    localparam logic [CW-1:0] LAST_BIT  = CW'(SHIFT_WIDTH - 1);

    logic [W-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic [W-1:0]  shifted;
    logic          word_done;
    logic          transfer;
    logic          slot_free;

    generate
        if (DIR_RIGHT) begin : g_right
            assign shifted = {bus.shiftin, q_q[W-1:1]};
        end else begin : g_left
            assign shifted = {q_q[W-2:0], bus.shiftin};
        end
    endgenerate

    // Handshake: a word moves to the consumer exactly on an edge where data_valid and
    // data_ready are both 1; data_out is frozen while valid and not yet taken.
    assign transfer  = valid_q & bus.data_ready;
    assign word_done = bus.enable & (cnt_q == LAST_BIT);
    assign slot_free = ~valid_q | bus.data_ready;

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (bus.sclr) begin
            q_d     = '0;
            cnt_d   = '0;
            dout_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (transfer) begin
                valid_d = 1'b0;
            end
            if (bus.enable) begin
                q_d = shifted;
                // Explicit wrap so non-power-of-two widths never reach unused counts.
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (word_done) begin
                if (slot_free) begin
                    dout_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            q_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.bit_count  = cnt_q;
    assign bus.data_out   = dout_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: three instances (LEFT/8, RIGHT/8, LEFT/5) share one
// stimulus stream and are compared every cycle against a bit-history reference model.
module tb_shift_deserializer;
    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clock = ~clock;

    logic sclr = 1'b0, enable = 1'b0, shiftin = 1'b0, data_ready = 1'b0;

    shift_deserializer_if #(.SHIFT_WIDTH(8)) if_l ();
    shift_deserializer_if #(.SHIFT_WIDTH(8)) if_r ();
    shift_deserializer_if #(.SHIFT_WIDTH(5)) if_5 ();

    assign if_l.sclr = sclr;  assign if_l.enable = enable;
    assign if_l.shiftin = shiftin;  assign if_l.data_ready = data_ready;
    assign if_r.sclr = sclr;  assign if_r.enable = enable;
    assign if_r.shiftin = shiftin;  assign if_r.data_ready = data_ready;
    assign if_5.sclr = sclr;  assign if_5.enable = enable;
    assign if_5.shiftin = shiftin;  assign if_5.data_ready = data_ready;

    shift_deserializer #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("LEFT"))  dut_l (.clock(clock), .aclr_n(aclr_n), .bus(if_l));
    shift_deserializer #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("RIGHT")) dut_r (.clock(clock), .aclr_n(aclr_n), .bus(if_r));
    shift_deserializer #(.SHIFT_WIDTH(5), .SHIFT_DIRECTION("LEFT"))  dut_5 (.clock(clock), .aclr_n(aclr_n), .bus(if_5));

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    // Each config remembers its last W received bits (oldest first); a word is the
    // history read out in the direction's bit order once W bits have been counted.
    int       cfg_w[3]     = '{8, 8, 5};
    bit       cfg_right[3] = '{1'b0, 1'b1, 1'b0};
    bit       hist[3][$];
    int       m_cnt[3];
    logic [7:0] m_dout[3];
    bit       m_valid[3];
    bit       m_ovr[3];

    // scoreboard for words observed leaving the LEFT/8 instance
    logic [7:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         xfers  = 0;

    function automatic logic [7:0] assemble(int c);
        int v = 0;
        for (int k = 0; k < cfg_w[c]; k++) begin
            if (cfg_right[c]) v += int'(hist[c][k]) * (1 << k);
            else              v += int'(hist[c][k]) * (1 << (cfg_w[c] - 1 - k));
        end
        return 8'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            hist[c].delete();
            for (int k = 0; k < cfg_w[c]; k++) hist[c].push_back(1'b0);
            m_cnt[c] = 0; m_dout[c] = 8'h00; m_valid[c] = 1'b0; m_ovr[c] = 1'b0;
        end
    endtask

    task automatic model_edge(bit s, bit e, bit si, bit r);
        if (s) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            bit complete = e && (m_cnt[c] == cfg_w[c] - 1);
            bit accept   = !m_valid[c] || r;
            if (m_valid[c] && r) m_valid[c] = 1'b0;
            if (e) begin
                hist[c].push_back(si);
                void'(hist[c].pop_front());
                m_cnt[c] = (m_cnt[c] + 1) % cfg_w[c];
            end
            if (complete) begin
                if (accept) begin
                    m_dout[c]  = assemble(c);
                    m_valid[c] = 1'b1;
                end else begin
                    m_ovr[c] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("l.q",     32'(if_l.q),          32'(assemble(0)));
        chk("l.cnt",   32'(if_l.bit_count),  32'(m_cnt[0]));
        chk("l.dout",  32'(if_l.data_out),   32'(m_dout[0]));
        chk("l.valid", 32'(if_l.data_valid), 32'(m_valid[0]));
        chk("l.ovr",   32'(if_l.overrun),    32'(m_ovr[0]));
        chk("r.q",     32'(if_r.q),          32'(assemble(1)));
        chk("r.cnt",   32'(if_r.bit_count),  32'(m_cnt[1]));
        chk("r.dout",  32'(if_r.data_out),   32'(m_dout[1]));
        chk("r.valid", 32'(if_r.data_valid), 32'(m_valid[1]));
        chk("r.ovr",   32'(if_r.overrun),    32'(m_ovr[1]));
        chk("w5.q",     32'(if_5.q),          32'(assemble(2)));
        chk("w5.cnt",   32'(if_5.bit_count),  32'(m_cnt[2]));
        chk("w5.dout",  32'(if_5.data_out),   32'(m_dout[2]));
        chk("w5.valid", 32'(if_5.data_valid), 32'(m_valid[2]));
        chk("w5.ovr",   32'(if_5.overrun),    32'(m_ovr[2]));
    endtask

    task automatic check_zero(string tag);
        chk({tag, ".l"},  {if_l.q, if_l.data_out, 13'(if_l.bit_count), if_l.data_valid, if_l.overrun}, 32'h0);
        chk({tag, ".r"},  {if_r.q, if_r.data_out, 13'(if_r.bit_count), if_r.data_valid, if_r.overrun}, 32'h0);
        chk({tag, ".w5"}, 32'({if_5.q, if_5.data_out, if_5.bit_count, if_5.data_valid, if_5.overrun}), 32'h0);
    endtask

    // ---------------- driver ----------------
    task automatic step(bit s, bit e, bit si, bit r);
        sclr = s; enable = e; shiftin = si; data_ready = r;
        if (mon_en && !s && if_l.data_valid && r) begin
            xfers++;
            if (exp_q.size() == 0) chk("xfer.extra", 32'(if_l.data_out), 32'hFFFF_FFFF);
            else                   chk("xfer.word",  32'(if_l.data_out), 32'(exp_q.pop_front()));
        end
        @(posedge clock);
        model_edge(s, e, si, r);
        #1;
        check_all();
    endtask

    task automatic send_word(logic [7:0] w, int n, bit r, bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'($urandom), r);
            end
            step(1'b0, 1'b1, w[i], r);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();
        #2;
        check_zero("rst.init");
        #10 aclr_n = 1'b1;

        // async reset in the middle of a word, away from the edge
        send_word(8'h05, 3, 1'b0, 1'b0);
        #2 aclr_n = 1'b0;
        #1 check_zero("rst.mid");
        model_reset();
        #3 aclr_n = 1'b1;
        send_word(8'hE7, 8, 1'b0, 1'b0);
        chk("rst.one_word", 32'(if_l.data_valid), 32'h1);
        chk("rst.word", 32'(if_l.data_out), 32'hE7);

        // bit ordering: A5 is a bit palindrome, so both directions assemble A5
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hA5, 8, 1'b0, 1'b0);
        chk("left.dout", 32'(if_l.data_out), 32'hA5);
        chk("left.q", 32'(if_l.q), 32'hA5);
        chk("left.cnt", 32'(if_l.bit_count), 32'h0);
        chk("right.dout", 32'(if_r.data_out), 32'hA5);

        // back-to-back with ready held, then again with enable gaps
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            exp_q.push_back(8'h3C);
            exp_q.push_back(8'hC3);
            xfers  = 0;
            mon_en = 1'b1;
            send_word(8'h3C, 8, 1'b1, pass == 1);
            send_word(8'hC3, 8, 1'b1, pass == 1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            mon_en = 1'b0;
            chk("b2b.xfers", 32'(xfers), 32'd2);
            chk("b2b.ovr", 32'(if_l.overrun), 32'h0);
        end

        // overrun: second word dropped while stalled
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h11, 8, 1'b0, 1'b0);
        send_word(8'h22, 8, 1'b0, 1'b0);
        chk("ovr.dout", 32'(if_l.data_out), 32'h11);
        chk("ovr.flag", 32'(if_l.overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.consumed", 32'(if_l.data_valid), 32'h0);
        chk("ovr.sticky", 32'(if_l.overrun), 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr.cleared", 32'(if_l.overrun), 32'h0);

        // sclr mid-word, then sclr together with enable
        send_word(8'h07, 3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sclr.cnt", 32'(if_l.bit_count), 32'h0);
        send_word(8'h5A, 8, 1'b0, 1'b0);
        chk("sclr.word", 32'(if_l.data_out), 32'h5A);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sclr_en.q", 32'(if_l.q), 32'h0);
        chk("sclr_en.cnt", 32'(if_l.bit_count), 32'h0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
